// File: rtl/datapath_p2.sv
// rtl/datapath_p2.sv - single-bus 32-bit CPU datapath (phase 2); optional MULDIV_EN adds mul/div
module datapath_p2 #(
    parameter int WIDTH = 32,
    parameter int NREGS = 16
) (
    input  logic             Clock,
    input  logic             Clear,
    output logic [WIDTH-1:0] outp,
    input  logic             PCout,
    input  logic             Zhiout,
    input  logic             Zlowout,
    input  logic             MDRout,
    input  logic             HIout,
    input  logic             LOout,
    input  logic             InPortout,
    input  logic             MARin,
    input  logic             Zin,
    input  logic             PCin,
    input  logic             MDRin,
    input  logic             IRin,
    input  logic             Yin,
    input  logic             HIin,
    input  logic             LOin,
    input  logic             OutPortin,
    input  logic             IncPC,
    input  logic             Read,
    input  logic             Write,
    input  logic             Gra,
    input  logic             Grb,
    input  logic             Grc,
    input  logic             Rin,
    input  logic             Rout,
    input  logic             BAout,
    input  logic             Cout,
    input  logic             CONIn,
    input  logic             Strobe,
    input  logic [WIDTH-1:0] Mdatain
);
    localparam int IW = $clog2(NREGS);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_SHR = 5'b00101;
    localparam logic [4:0] OP_SHL = 5'b00110;
    localparam logic [4:0] OP_ROR = 5'b00111;
    localparam logic [4:0] OP_ROL = 5'b01000;
    localparam logic [4:0] OP_AND = 5'b01001;
    localparam logic [4:0] OP_OR  = 5'b01010;
    localparam logic [4:0] OP_ANDI = 5'b01100;
    localparam logic [4:0] OP_ORI = 5'b01101;
    localparam logic [4:0] OP_MUL = 5'b01110;
    localparam logic [4:0] OP_DIV = 5'b01111;
    localparam logic [4:0] OP_NEG = 5'b10000;
    localparam logic [4:0] OP_NOT = 5'b10001;
    localparam logic [4:0] OP_LD  = 5'b00000;
    localparam logic [4:0] OP_LDI = 5'b00001;
    localparam logic [4:0] OP_ST  = 5'b00010;
    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_BR  = 5'b10010;
    localparam logic [4:0] OP_JAL = 5'b10100;

    logic [WIDTH-1:0]   regs [NREGS];
    logic [WIDTH-1:0]   pc, ir, mar, mdr, y, hi, lo, in_port, out_port;
    logic [2*WIDTH-1:0] z;
    logic               con;

    logic [WIDTH-1:0]   bus;
    logic [IW-1:0]      sel_idx;
    logic [4:0]         opcode;
    logic [WIDTH-1:0]   c_sext;
    logic [2*WIDTH-1:0] alu_res;
    logic               con_next;

    // Memory writes are handled outside the datapath in this phase.
    logic unused_write;
    assign unused_write = Write;

    assign opcode = ir[31:27];
    assign c_sext = {{(WIDTH-19){ir[18]}}, ir[18:0]};
    assign outp   = out_port;

    always_comb begin
        sel_idx = '0;
        if (Gra)      sel_idx = ir[26:23];
        else if (Grb) sel_idx = ir[22:19];
        else if (Grc) sel_idx = ir[18:15];
    end

    always_comb begin
        bus = '0;
        if (PCout)          bus = pc;
        else if (Zhiout)    bus = z[2*WIDTH-1:WIDTH];
        else if (Zlowout)   bus = z[WIDTH-1:0];
        else if (MDRout)    bus = mdr;
        else if (HIout)     bus = hi;
        else if (LOout)     bus = lo;
        else if (InPortout) bus = in_port;
        else if (Rout)      bus = regs[sel_idx];
        else if (BAout)     bus = (sel_idx == '0) ? '0 : regs[sel_idx];
        else if (Cout)      bus = c_sext;
    end

    // A is Y, B is the bus; rotates work on a doubled copy of A.
    logic [2*WIDTH-1:0] a_dbl;
    logic [4:0]         sh;
    assign a_dbl = {y, y};
    assign sh    = bus[4:0];

`ifdef MULDIV_EN
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quotient, remainder;
    assign product = {{WIDTH{y[WIDTH-1]}}, y} * {{WIDTH{bus[WIDTH-1]}}, bus};
    always_comb begin
        quotient  = '0;
        remainder = '0;
        if (bus != '0) begin
            quotient  = $signed(y) / $signed(bus);
            remainder = $signed(y) % $signed(bus);
        end
    end
`endif

    always_comb begin
        alu_res = '0;
        if (IncPC) begin
            alu_res = {{WIDTH{1'b0}}, bus + ONE};
        end else begin
            case (opcode)
                OP_ADD, OP_LD, OP_LDI, OP_ST, OP_ADDI, OP_BR, OP_JAL:
                            alu_res = {{WIDTH{1'b0}}, y + bus};
                OP_SUB:     alu_res = {{WIDTH{1'b0}}, y - bus};
                OP_SHR:     alu_res = {{WIDTH{1'b0}}, y >> sh};
                OP_SHL:     alu_res = {{WIDTH{1'b0}}, y << sh};
                OP_ROR:     alu_res = {{WIDTH{1'b0}}, a_dbl[WIDTH-1:0] >> sh | y << (6'd32 - {1'b0, sh})};
                OP_ROL:     alu_res = {{WIDTH{1'b0}}, y << sh | a_dbl[2*WIDTH-1:WIDTH] >> (6'd32 - {1'b0, sh})};
                OP_AND, OP_ANDI:
                            alu_res = {{WIDTH{1'b0}}, y & bus};
                OP_OR, OP_ORI:
                            alu_res = {{WIDTH{1'b0}}, y | bus};
`ifdef MULDIV_EN
                OP_MUL:     alu_res = product;
                OP_DIV:     alu_res = {remainder, quotient};
`else
                OP_MUL, OP_DIV:
                            alu_res = '0;
`endif
                OP_NEG:     alu_res = {{WIDTH{1'b0}}, '0 - bus};
                OP_NOT:     alu_res = {{WIDTH{1'b0}}, ~bus};
                default:    alu_res = {{WIDTH{1'b0}}, bus};
            endcase
        end
    end

    always_comb begin
        con_next = 1'b0;
        case (ir[20:19])
            2'b00: con_next = (bus == '0);
            2'b01: con_next = (bus != '0);
            2'b10: con_next = ~bus[WIDTH-1];
            2'b11: con_next = bus[WIDTH-1];
            default: con_next = 1'b0;
        endcase
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            pc       <= '0;
            ir       <= '0;
            mar      <= '0;
            mdr      <= '0;
            y        <= '0;
            z        <= '0;
            hi       <= '0;
            lo       <= '0;
            con      <= 1'b0;
            in_port  <= '0;
            out_port <= '0;
        end else begin
            if (Rin)       regs[sel_idx] <= bus;
            if (PCin)      pc       <= bus;
            if (IRin)      ir       <= bus;
            if (MARin)     mar      <= bus;
            if (MDRin)     mdr      <= Read ? Mdatain : bus;
            if (Yin)       y        <= bus;
            if (Zin)       z        <= alu_res;
            if (HIin)      hi       <= bus;
            if (LOin)      lo       <= bus;
            if (CONIn)     con      <= con_next;
            if (Strobe)    in_port  <= Mdatain;
            if (OutPortin) out_port <= bus;
        end
    end
endmodule

// File: tb/tb_datapath_p2.sv
// tb/tb_datapath_p2.sv - self-checking bench for datapath_p2 (vector table, random ALU ops, sequences)
module tb_datapath_p2;
    logic        Clock, Clear;
    logic [31:0] outp, Mdatain;
    logic PCout, Zhiout, Zlowout, MDRout, HIout, LOout, InPortout;
    logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin;
    logic IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONIn, Strobe;

    int checks = 0;
    int errors = 0;

    datapath_p2 dut (
        .Clock(Clock), .Clear(Clear), .outp(outp),
        .PCout(PCout), .Zhiout(Zhiout), .Zlowout(Zlowout), .MDRout(MDRout),
        .HIout(HIout), .LOout(LOout), .InPortout(InPortout),
        .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
        .Yin(Yin), .HIin(HIin), .LOin(LOin), .OutPortin(OutPortin),
        .IncPC(IncPC), .Read(Read), .Write(Write),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .Cout(Cout), .CONIn(CONIn), .Strobe(Strobe), .Mdatain(Mdatain)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic idle();
        {PCout, Zhiout, Zlowout, MDRout, HIout, LOout, InPortout} = '0;
        {MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin} = '0;
        {IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONIn, Strobe} = '0;
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
        idle();
    endtask

    task automatic mem_to_mdr(input logic [31:0] v);
        Mdatain = v; Read = 1; MDRin = 1; step();
    endtask

    task automatic load_ir(input logic [31:0] v);
        mem_to_mdr(v); MDRout = 1; IRin = 1; step();
    endtask

    task automatic write_reg(input int g, input logic [31:0] v);
        mem_to_mdr(v);
        MDRout = 1; Rin = 1; Gra = (g == 0); Grb = (g == 1); Grc = (g == 2);
        step();
    endtask

    task automatic run_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] lo_v, output logic [31:0] hi_v);
        load_ir({op, 27'b0});
        mem_to_mdr(a); MDRout = 1; Yin = 1; step();
        mem_to_mdr(b); MDRout = 1; Zin = 1; step();
        Zlowout = 1; LOin = 1; OutPortin = 1; step(); lo_v = outp;
        Zhiout = 1; HIin = 1; OutPortin = 1; step(); hi_v = outp;
    endtask

    // Reference ALU built straight from the instruction set's arithmetic meaning.
    function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint unsigned aa = {32'b0, a};
        int s = int'(b[4:0]);
        logic [31:0] r;
        case (op)
            5'd4:  r = a - b;
            5'd5:  r = a >> s;
            5'd6:  r = a << s;
            5'd7:  r = 32'((aa >> s) | (aa << (32 - s)));
            5'd8:  r = 32'((aa << s) | (aa >> (32 - s)));
            5'd9, 5'd12:  r = a & b;
            5'd10, 5'd13: r = a | b;
            5'd14: begin
`ifdef MULDIV_EN
                longint p = longint'($signed(a)) * longint'($signed(b));
                return p;
`else
                return 64'd0;
`endif
            end
            5'd15: begin
`ifdef MULDIV_EN
                int q, m;
                if (b == 0) return 64'd0;
                q = $signed(a) / $signed(b);
                m = $signed(a) % $signed(b);
                return {m, q};
`else
                return 64'd0;
`endif
            end
            5'd16: r = -b;
            5'd17: r = ~b;
            5'd0, 5'd1, 5'd2, 5'd3, 5'd11, 5'd18, 5'd20: r = a + b;
            default: r = b;
        endcase
        return {32'b0, r};
    endfunction

    initial begin
        logic [31:0] lo_v, hi_v;
        logic [4:0]  op;
        logic [31:0] a, b;
        logic [63:0] exp;

        vecs[0]  = '{5'b00011, 32'd7, 32'hFFFFFFFE, 32'd5, 32'd0};
        vecs[1]  = '{5'b00100, 32'd7, 32'hFFFFFFFE, 32'd9, 32'd0};
        vecs[2]  = '{5'b00110, 32'd1, 32'd31, 32'h80000000, 32'd0};
        vecs[3]  = '{5'b00111, 32'd1, 32'd1, 32'h80000000, 32'd0};
        vecs[4]  = '{5'b01000, 32'h80000000, 32'd1, 32'd1, 32'd0};
        vecs[5]  = '{5'b00101, 32'h80000000, 32'd31, 32'd1, 32'd0};
        vecs[6]  = '{5'b01001, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 32'd0};
        vecs[7]  = '{5'b01101, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 32'd0};
        vecs[8]  = '{5'b10000, 32'd99, 32'd1, 32'hFFFFFFFF, 32'd0};
        vecs[9]  = '{5'b10001, 32'd99, 32'd0, 32'hFFFFFFFF, 32'd0};
        vecs[10] = '{5'b11111, 32'd99, 32'h00001234, 32'h00001234, 32'd0};
`ifdef MULDIV_EN
        vecs[11] = '{5'b01110, 32'hFFFFFFFD, 32'd4, 32'hFFFFFFF4, 32'hFFFFFFFF};
        vecs[12] = '{5'b01111, 32'd7, 32'd2, 32'd3, 32'd1};
`else
        vecs[11] = '{5'b01110, 32'hFFFFFFFD, 32'd4, 32'd0, 32'd0};
        vecs[12] = '{5'b01111, 32'd7, 32'd2, 32'd0, 32'd0};
`endif
        vecs[13] = '{5'b01111, 32'd7, 32'd0, 32'd0, 32'd0};

        Clock = 0; Clear = 0; Mdatain = 0;
        idle();
        #12;
        check("reset_outp", {32'b0, outp}, 64'd0);
        check("reset_z", dut.z, 64'd0);
        Clear = 1;
        @(posedge Clock); #1;

        for (int i = 0; i < 14; i++) begin
            run_alu(vecs[i].op, vecs[i].a, vecs[i].b, lo_v, hi_v);
            check($sformatf("vec%0d_lo", i), {32'b0, lo_v}, {32'b0, vecs[i].lo});
            check($sformatf("vec%0d_hi", i), {32'b0, hi_v}, {32'b0, vecs[i].hi});
        end
        HIout = 1; OutPortin = 1; step();
        check("hiout_bus", {32'b0, outp}, {32'b0, vecs[13].hi});
        LOout = 1; OutPortin = 1; step();
        check("loout_bus", {32'b0, outp}, {32'b0, vecs[13].lo});

        for (int i = 0; i < 40; i++) begin
            op = 5'($urandom_range(0, 31));
            a  = $urandom;
            b  = (i % 3 == 0) ? 32'($urandom_range(0, 31)) : $urandom;
            run_alu(op, a, b, lo_v, hi_v);
            exp = ref_alu(op, a, b);
            check($sformatf("rand%0d_op%0d", i, op), {hi_v, lo_v}, exp);
        end

        // add R3,R1,R2 through the register file
        load_ir({5'b00011, 4'd3, 4'd1, 4'd2, 15'b0});
        write_reg(1, 32'd7);
        write_reg(2, 32'hFFFFFFFE);
        Grb = 1; Rout = 1; Yin = 1; step();
        Grc = 1; Rout = 1; Zin = 1; step();
        Zlowout = 1; Gra = 1; Rin = 1; step();
        Gra = 1; Rout = 1; OutPortin = 1; step();
        check("add_r3", {32'b0, outp}, 64'd5);

        // R0 is hidden under BAout but readable under Rout
        load_ir(32'h0);
        write_reg(0, 32'h55);
        Gra = 1; BAout = 1; OutPortin = 1; step();
        check("baout_r0", {32'b0, outp}, 64'd0);
        Gra = 1; Rout = 1; OutPortin = 1; step();
        check("rout_r0", {32'b0, outp}, 64'h55);

        OutPortin = 1; step();
        check("bus_idle", {32'b0, outp}, 64'd0);
        mem_to_mdr(32'hDEADBEEF);
        PCout = 1; MDRout = 1; OutPortin = 1; step();
        check("bus_prio_pc", {32'b0, outp}, {32'b0, dut.pc});
        MDRout = 1; Cout = 1; OutPortin = 1; step();
        check("bus_prio_mdr", {32'b0, outp}, 64'hDEADBEEF);
        Mdatain = 32'hA5A5_0001; Strobe = 1; step();
        InPortout = 1; OutPortin = 1; step();
        check("inport", {32'b0, outp}, 64'hA5A50001);

        Clear = 0;
        #2;
        check("midreset_outp", {32'b0, outp}, 64'd0);
        check("midreset_r3", {32'b0, dut.regs[3]}, 64'd0);
        check("midreset_z", dut.z, 64'd0);
        check("midreset_hi", {32'b0, dut.hi}, 64'd0);
        Clear = 1;

        // fetch
        PCout = 1; MARin = 1; IncPC = 1; Zin = 1; step();
        check("fetch_mar", {32'b0, dut.mar}, 64'd0);
        check("fetch_z", dut.z, 64'd1);
        Zlowout = 1; PCin = 1; Read = 1; MDRin = 1; Mdatain = 32'h91100023; step();
        check("fetch_pc", {32'b0, dut.pc}, 64'd1);
        check("fetch_mdr", {32'b0, dut.mdr}, 64'h91100023);
        MDRout = 1; IRin = 1; step();
        check("fetch_ir", {32'b0, dut.ir}, 64'h91100023);

        // brpl R2,35
        write_reg(0, 32'd5);
        Gra = 1; Rout = 1; CONIn = 1; step();
        check("brpl_con_taken", {63'b0, dut.con}, 64'd1);
        PCout = 1; Yin = 1; step();
        Cout = 1; Zin = 1; step();
        check("brpl_z", dut.z, 64'd36);
        Zlowout = 1; PCin = 1; step();
        check("brpl_pc", {32'b0, dut.pc}, 64'd36);
        write_reg(0, 32'hFFFFFFFF);
        Gra = 1; Rout = 1; CONIn = 1; step();
        check("brpl_con_not", {63'b0, dut.con}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
